vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
- Transaction controller for the coin-operated seller.
- Accumulates credit from half/one/two-unit coin pulses and lets the user pick one of two products at configurable prices.
- Issues a one-cycle vend pulse when a purchase is accepted, then pays back the remaining credit one coin at a time over a req/ack handshake to the change dispenser.
- Sits between the coin acceptor and the dispense/change actuators. All amounts are in half-unit counts (1 = 0.5 yuan).

Parameters:
- PRICE_A, 3, price of product A in half-units (1.5).
- PRICE_B, 5, price of product B in half-units (2.5).
- CREDIT_W, 4, width of the credit register.
- MAX_CREDIT, 10, credit ceiling in half-units; must be < 2**CREDIT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- d1  in  1  0.5-unit coin, one-cycle pulse.
- d2  in  1  1-unit coin, one-cycle pulse.
- d3  in  1  2-unit coin, one-cycle pulse.
- sel_a  in  1  select product A, one-cycle pulse.
- sel_b  in  1  select product B, one-cycle pulse.
- cancel  in  1  refund request, one-cycle pulse.
- chg_ack  in  1  dispenser has released the coin presented on chg_val.
- out_a  out  1  vend product A, one-cycle pulse.
- out_b  out  1  vend product B, one-cycle pulse.
- coin_rej  out  1  inserted coin returned, one-cycle pulse.
- chg_req  out  1  change coin request, held until acked.
- chg_val  out  2  change coin value: 1 = 0.5, 2 = 1.0; 0 when idle.
- credit  out  CREDIT_W  current credit in half-units.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (rst = 0 at a clk edge): state IDLE, credit 0, every output 0.
- All outputs are registered. Coin values: d1 = 1, d2 = 2, d3 = 4 half-units.
- Legal coin: exactly one of d1/d2/d3 is high. Multi-hot coin input produces coin_rej = 1 next cycle and no credit change.
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE/COLLECT coin acceptance:
  - A legal coin with credit + value <= MAX_CREDIT is added next cycle; state goes to COLLECT.
  - If the sum would exceed MAX_CREDIT, coin_rej pulses and credit is unchanged.
- Request priority in COLLECT: cancel > sel_a > sel_b > coin.
  - cancel with credit > 0: go to CHANGE. Any coin that cycle is rejected.
  - sel_x with credit >= PRICE_x, evaluated on registered credit: go to VEND. Next cycle out_x = 1 and credit -= PRICE_x. Any coin that cycle is rejected.
  - sel_x with insufficient credit: ignored. A coin in the same cycle is still accepted.
  - Simultaneous sel_a and sel_b: A wins, B is ignored.
- VEND lasts one cycle: go to CHANGE if credit > 0, else IDLE.
- VEND/CHANGE: every coin gets coin_rej; sel and cancel are ignored.
- CHANGE handshake:
  - Assert chg_req, with chg_val = 2 if credit >= 2, else 1.
  - Hold chg_req and chg_val stable until the cycle chg_ack = 1 is sampled.
  - On ack: credit -= chg_val and drop chg_req for one cycle. Then re-request if credit > 0, else go to IDLE.
  - chg_ack while chg_req = 0 is ignored.
- IDLE with credit 0: sel and cancel are ignored.
- Reset mid-transaction: credit is discarded and chg_req drops immediately at that edge; no refund.
- Invariant: credit never exceeds MAX_CREDIT and never underflows.

Decomposition:
- Shared package `seller_pkg`: state enum; coin value constants (HALF = 1, ONE = 2, TWO = 4); CHG_HALF / CHG_ONE encodings.
- Optional sub-module `coin_decode`: maps d1/d2/d3 to a value and a legal flag.
- Everything else stays in one module.

Test Plan:
1. d2, d2 -> credit 4; sel_a -> out_a pulse, credit 1; chg_req with chg_val = 1; ack -> credit 0, state IDLE.
2. d3, d1 (credit 5); sel_b -> out_b, credit 0; no chg_req; state IDLE.
3. d1 (credit 1); sel_a -> no vend; cancel -> one chg_val = 1 request; hold chg_ack low 5 cycles -> chg_req stays 1 and chg_val stays 1 throughout.
4. d3 ×2, then d2 (credit 10); d1 -> coin_rej, credit 10; d1 and d2 together -> coin_rej; sel_a -> credit 7 -> change sequence 2, 2, 2, 1.
5. Credit 5, sel_a, sel_b and d1 in the same cycle -> out_a only, coin_rej, credit 2, then one chg_val = 2 request.
6. Credit 6 in CHANGE with chg_req = 1; rst low one cycle -> credit 0, chg_req 0, state IDLE; a following d2 is accepted normally.

Source files
------------

// File: rtl/seller_pkg.sv
// Shared types and constants for the coin-operated seller controllers.
package seller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int COIN_W = 3;

  localparam logic [COIN_W-1:0] HALF = 3'd1;
  localparam logic [COIN_W-1:0] ONE  = 3'd2;
  localparam logic [COIN_W-1:0] TWO  = 3'd4;

  localparam logic [1:0] CHG_HALF = 2'd1;
  localparam logic [1:0] CHG_ONE  = 2'd2;

endpackage

// File: rtl/coin_decode.sv
// Maps the three coin pulse lines to a half-unit value; only one-hot inputs are legal.
module coin_decode
  import seller_pkg::*;
(
  input  logic              d1,
  input  logic              d2,
  input  logic              d3,
  output logic [COIN_W-1:0] value,
  output logic              legal,
  output logic              any
);

  always_comb begin
    value = '0;
    legal = 1'b0;
    case ({d3, d2, d1})
      3'b001: begin value = HALF; legal = 1'b1; end
      3'b010: begin value = ONE;  legal = 1'b1; end
      3'b100: begin value = TWO;  legal = 1'b1; end
      default: begin value = '0;  legal = 1'b0; end
    endcase
  end

  assign any = d1 | d2 | d3;

endmodule

// File: rtl/vend_ctrl.sv
// Seller transaction controller: credit accumulation, product vend and coin-by-coin change payout.
//   state   | meaning
//   IDLE    | no credit held, waiting for the first coin
//   COLLECT | credit held, accepting coins / select / cancel
//   VEND    | one-cycle vend pulse in flight, next decides on change
//   CHANGE  | paying back credit over chg_req/chg_ack
module vend_ctrl #(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 5,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d1,
  input  logic                d2,
  input  logic                d3,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel,
  input  logic                chg_ack,
  output logic                out_a,
  output logic                out_b,
  output logic                coin_rej,
  output logic                chg_req,
  output logic [1:0]          chg_val,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  import seller_pkg::*;

  localparam logic [CREDIT_W-1:0] PA   = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB   = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0]   MAXC = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic [COIN_W-1:0]   coin_val;
  logic                coin_legal;
  logic                coin_any;
  logic [CREDIT_W:0]   sum;
  logic                coin_fits;
  logic                has_credit;
  logic [1:0]          chg_pick;

  coin_decode u_coin_decode (
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .value (coin_val),
    .legal (coin_legal),
    .any   (coin_any)
  );

  assign sum        = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
  assign coin_fits  = coin_legal && (sum <= MAXC);
  assign has_credit = (credit != '0);
  // Largest change coin that does not exceed the remaining credit.
  assign chg_pick   = (credit >= CREDIT_W'(2)) ? CHG_ONE : CHG_HALF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      credit   <= '0;
      out_a    <= 1'b0;
      out_b    <= 1'b0;
      coin_rej <= 1'b0;
      chg_req  <= 1'b0;
      chg_val  <= '0;
      busy     <= 1'b0;
    end else begin
      out_a    <= 1'b0;
      out_b    <= 1'b0;
      coin_rej <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (has_credit && cancel) begin
            state    <= CHANGE;
            busy     <= 1'b1;
            chg_req  <= 1'b1;
            chg_val  <= chg_pick;
            coin_rej <= coin_any;
          end else if (has_credit && sel_a && credit >= PA) begin
            state    <= VEND;
            busy     <= 1'b1;
            out_a    <= 1'b1;
            credit   <= credit - PA;
            coin_rej <= coin_any;
          end else if (has_credit && sel_b && credit >= PB) begin
            state    <= VEND;
            busy     <= 1'b1;
            out_b    <= 1'b1;
            credit   <= credit - PB;
            coin_rej <= coin_any;
          end else if (coin_fits) begin
            state  <= COLLECT;
            credit <= sum[CREDIT_W-1:0];
          end else begin
            coin_rej <= coin_any;
          end
        end
        VEND: begin
          coin_rej <= coin_any;
          if (has_credit) begin
            state   <= CHANGE;
            chg_req <= 1'b1;
            chg_val <= chg_pick;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_rej <= coin_any;
          if (chg_req) begin
            if (chg_ack) begin
              credit  <= credit - CREDIT_W'(chg_val);
              chg_req <= 1'b0;
              chg_val <= '0;
            end
          end else if (has_credit) begin
            chg_req <= 1'b1;
            chg_val <= chg_pick;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
